// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: streams two W-bit operands, one nibble per cycle,
// through an external 4-bit ripple-carry adder stage. The carry is chained
// through a register, and the wide sum, carry-out and signed overflow are
// assembled here.
module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_ci,
  input  logic [3:0]   add_s,
  input  logic         add_co
);

  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_sh_q, a_sh_d;
  logic [W-1:0]       b_sh_q, b_sh_d;
  logic [W-1:0]       sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               last_nib;

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // Next-state, datapath update and adder-stage drive for the serial add.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_ci   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = op_a;
          b_sh_d   = op_b;
          carry_d  = cin;
          idx_d    = '0;
          a_msb_d  = op_a[W-1];
          b_msb_d  = op_b[W-1];
          sum_sh_d = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        add_a    = a_sh_q[3:0];
        add_b    = b_sh_q[3:0];
        add_ci   = carry_q;
        a_sh_d   = {4'd0, a_sh_q[W-1:4]};
        b_sh_d   = {4'd0, b_sh_q[W-1:4]};
        sum_sh_d = {add_s, sum_sh_q[W-1:4]};
        carry_d  = add_co;
        idx_d    = idx_q + IDX_W'(1);
        if (last_nib) begin
          // Top nibble: the shifted-in add_s completes the wide sum, and its
          // bit 3 is the result sign used for the overflow test.
          sum_d   = {add_s, sum_sh_q[W-1:4]};
          cout_d  = add_co;
          ovf_d   = (a_msb_q == b_msb_q) && (add_s[3] != a_msb_q);
          idx_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder with a behavioural 4-bit adder stage,
// a vector table and a result scoreboard.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_ci;
  logic [3:0]   add_s;
  logic         add_co;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_ci (add_ci),
    .add_s  (add_s),
    .add_co (add_co)
  );

  // External 4-bit ripple-carry stage, modelled behaviourally.
  assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        res_t r;
        r = sb.pop_front();
        chk("sum", 32'(sum), 32'(r.s));
        chk("cout", 32'(cout), 32'(r.co));
        chk("ovf", 32'(ovf), 32'(r.ov));
      end
    end
  end

  // One operation with timing checks; optionally pulses start during RUN
  // and during DONE to show those requests are dropped.
  task automatic do_op(input vec_t v, input bit pulse_run, input bit pulse_done);
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    res_t         r;
    int           waited;
    r.s = v.s; r.co = v.co; r.ov = v.ov;
    @(negedge clk);
    op_a = v.a; op_b = v.b; cin = v.ci; start = 1'b1;
    sb.push_back(r);
    @(negedge clk);
    start = 1'b0;
    ra = '0; rb = '0;
    for (int k = 0; k < N; k++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      ra[4*k +: 4] = add_a;
      rb[4*k +: 4] = add_b;
      if (k == 0) chk("add_ci_first", 32'(add_ci), 32'(v.ci));
      if (pulse_run && k == 1) begin
        start = 1'b1; op_a = ~v.a; op_b = 16'h0F0F; cin = ~v.ci;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("add_a_seq", 32'(ra), 32'(v.a));
    chk("add_b_seq", 32'(rb), 32'(v.b));
    chk("done_latency", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("add_a_idle", 32'(add_a), 32'd0);
    waited = 0;
    while (!done && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    if (pulse_done) begin
      start = 1'b1; op_a = 16'h5A5A; op_b = 16'h1111; cin = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("sum_hold", 32'(sum), 32'(v.s));
    if (pulse_run || pulse_done) begin
      for (int t = 0; t < N + 3; t++) begin
        chk("no_second_op", 32'(busy), 32'd0);
        @(negedge clk);
      end
      chk("sum_after_ignore", 32'(sum), 32'(v.s));
    end
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    vecs[0] = '{a:16'h1234, b:16'h4321, ci:1'b0, s:16'h5555, co:1'b0, ov:1'b0};
    vecs[1] = '{a:16'hFFFF, b:16'h0001, ci:1'b0, s:16'h0000, co:1'b1, ov:1'b0};
    vecs[2] = '{a:16'h7FFF, b:16'h0001, ci:1'b0, s:16'h8000, co:1'b0, ov:1'b1};
    vecs[3] = '{a:16'h8000, b:16'h8000, ci:1'b0, s:16'h0000, co:1'b1, ov:1'b1};
    vecs[4] = '{a:16'h0FFF, b:16'h0000, ci:1'b1, s:16'h1000, co:1'b0, ov:1'b0};
    vecs[5] = '{a:16'hFFFF, b:16'hFFFF, ci:1'b1, s:16'hFFFF, co:1'b1, ov:1'b0};
    vecs[6] = '{a:16'h8000, b:16'hFFFF, ci:1'b0, s:16'h7FFF, co:1'b1, ov:1'b1};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_add", 32'({add_a, add_b, add_ci}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start pulses during RUN and DONE are dropped
    do_op(vecs[0], 1'b1, 1'b1);

    for (int i = 0; i < 7; i++) do_op(vecs[i], 1'b0, 1'b0);

    // Reset while nibble 2 is on the adder: outputs clear, no done pulse.
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_add_a_nib2", 32'(add_a), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_add", 32'({add_a, add_b, add_ci}), 32'd0);
    for (int t = 0; t < N + 2; t++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    v = '{a:16'h0001, b:16'h0002, ci:1'b0, s:16'h0003, co:1'b0, ov:1'b0};
    do_op(v, 1'b0, 1'b0);

    repeat (N + 3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential front-end that adds two NIBBLES×4-bit operands by streaming them, one nibble per cycle, through the existing 4-bit ripple-carry adder stage. It feeds that stage's a/b/ci inputs and consumes its s/carry-out outputs. It chains the carry through a register and assembles the wide sum, carry-out and signed-overflow flag. It sits between the operand source, which uses a start/done handshake, and the 4-bit adder instance, which is external to this block.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A; latched when start is accepted.
- op_b  in  W  operand B; latched when start is accepted.
- cin  in  1  carry-in to nibble 0; latched with the operands.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  registered result; held until the next accepted start.
- cout  out  1  carry out of the top nibble; registered.
- ovf  out  1  two's-complement overflow; registered.
- add_a  out  4  to 4-bit adder a.
- add_b  out  4  to 4-bit adder b.
- add_ci  out  1  to 4-bit adder carry-in.
- add_s  in  4  from 4-bit adder sum; purely combinational from add_a/add_b/add_ci.
- add_co  in  1  from 4-bit adder carry-out.

## Operation
- States: IDLE, RUN, DONE. Nibble counter idx counts 0..NIBBLES-1.
- IDLE with start=1: latch op_a/op_b into shift registers a_sh/b_sh; carry_r ← cin; idx ← 0; go to RUN. Record sign bits a_msb and b_msb.
- IDLE with start=0: hold all registers.
- RUN, every cycle:
  - Drive add_a=a_sh[3:0], add_b=b_sh[3:0], add_ci=carry_r.
  - On the edge: a_sh and b_sh shift right by 4; sum_sh shifts right by 4 with add_s entering at bits [W-1:W-4]; carry_r ← add_co; idx++.
- RUN, idx=NIBBLES-1: additionally load sum ← final sum_sh, cout ← add_co, ovf ← (a_msb==b_msb) && (add_s[3]!=a_msb). Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE; there is no queueing, so the source must wait for done.
- Outside RUN: add_a=0, add_b=0, add_ci=0.
- Arithmetic: sum = (op_a + op_b + cin) mod 2^W. cout is bit W of the full sum. No width extension.
- Reset (async assert, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0, add_*=0, all internal registers 0. Reset mid-RUN aborts the operation with no done pulse. After deassertion the next start is accepted normally.

## Timing
- start sampled at edge E0 → busy high from E0 through E0+NIBBLES.
- Nibble k is presented during cycle k+1 after E0 and captured at edge E0+k+1.
- sum/cout/ovf are updated at edge E0+NIBBLES. done is high for the cycle following that edge.
- Latency, start edge to done edge: NIBBLES+1 cycles. Minimum start-to-start spacing: NIBBLES+2 cycles; back-to-back start is accepted only once IDLE is re-entered.
- The adder path is a combinational loop-free single-cycle path: add_a→add_s→sum_sh register.
- Outputs sum/cout/ovf change only at the result edge or on reset. They are stable while done=1 and afterwards.

## Test plan
- NIBBLES=4: op_a=0x1234, op_b=0x4321, cin=0 → done 5 cycles after start; sum=0x5555, cout=0, ovf=0. Bench checks add_a sequence 4,3,2,1.
- op_a=0xFFFF, op_b=0x0001, cin=0 → carry ripples through all nibbles; sum=0x0000, cout=1, ovf=0.
- op_a=0x7FFF, op_b=0x0001 → sum=0x8000, cout=0, ovf=1. Then op_a=0x8000, op_b=0x8000 → sum=0x0000, cout=1, ovf=1.
- op_a=0x0FFF, op_b=0x0000, cin=1 → sum=0x1000, cout=0.
- Pulse start with new operands during RUN and during DONE → ignored. The first result is unchanged, busy and done timing are unchanged, and the second operation does not run.
- Assert rst_n=0 during nibble 2 of an operation → all outputs 0 immediately, no done pulse. Release reset and start op_a=0x0001, op_b=0x0002 → sum=0x0003 with normal latency.
